snn_sequencer: RTL and testbench
================================

SNN_SEQUENCER -- requirements
Module: snn_sequencer

Interface
REQ-001 SHALL have parameter INPUT_BYTES, default 2: payload bytes for an input-vector load.
REQ-002 SHALL have parameter WEIGHT_BYTES, default 80: payload bytes for a weight load.
REQ-003 SHALL have parameter BN_BYTES, default 40: payload bytes for a batchnorm load.
REQ-004 SHALL have parameter NUM_OUTPUTS, default 8: number of output spike lanes counted.
REQ-005 SHALL have parameter PIPE_LAT, default 3: cycles from the first execute cycle to the first valid output spike.
REQ-006 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port reset, input, 1: synchronous reset, active-high.
REQ-008 SHALL have port cmd_data, input, 8: host command or payload byte.
REQ-009 SHALL have port cmd_valid, input, 1: cmd_data is valid.
REQ-010 SHALL have port cmd_ready, output, 1: the sequencer accepts cmd_data this cycle.
REQ-011 SHALL have port spikes, input, NUM_OUTPUTS: output-layer spikes from the network.
REQ-012 SHALL have port data_out, output, 8: byte to the network setup data input.
REQ-013 SHALL have port setup_control, output, 3: network setup select.
REQ-014 SHALL have port execute, output, 1: network execute enable.
REQ-015 SHALL have port res_data, output, 8: spike-count result byte.
REQ-016 SHALL have port res_valid, input/output as follows: output, 1: res_data is valid.
REQ-017 SHALL have port res_ready, input, 1: the host accepts res_data.
REQ-018 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-019 A transfer SHALL occur on a cycle with valid and ready both high; data SHALL be ignored otherwise.
REQ-020 Command byte [7:6] SHALL decode as: 00 load inputs, 01 load weights, 10 load batchnorm, 11 run. Run T = cmd[5:0]+1 (1..64).
REQ-021 States SHALL be IDLE, LOAD, RUN, DRAIN and REPORT.
REQ-022 IDLE: cmd_ready=1. A load command SHALL go to LOAD with remaining = INPUT_BYTES, WEIGHT_BYTES or BN_BYTES; a run command SHALL go to RUN.
REQ-023 LOAD: cmd_ready=1. Each accepted byte SHALL be registered to data_out.
REQ-024 LOAD: on the cycle after each accepted byte, setup_control SHALL equal the load code (000 inputs, 001 weights, 110 batchnorm) for exactly one cycle.
REQ-025 Whenever no payload byte is being presented, setup_control SHALL be 3'b010 (neutral), so the network shifts exactly once per byte.
REQ-026 LOAD: after the last byte is accepted, the FSM SHALL return to IDLE. Back-to-back bytes SHALL be supported at one per cycle.
REQ-027 RUN entry SHALL clear all spike counters. cmd_ready SHALL be 0 in RUN, DRAIN and REPORT.
REQ-028 RUN: execute SHALL be high for exactly T consecutive cycles, starting the cycle after the run command is accepted; the FSM then goes to DRAIN.
REQ-029 Sampling window: spike lane i SHALL be sampled on exactly the T cycles that begin PIPE_LAT cycles after the first execute cycle.
REQ-030 Each counter i SHALL increment by 1 when spikes[i]=1 in a window cycle; counters are 8-bit and SHALL saturate at 255.
REQ-031 DRAIN SHALL end on the last window cycle, then go to REPORT; execute SHALL be 0 in DRAIN.
REQ-032 REPORT: res_valid=1 and res_data = count[idx], with idx starting at 0.
REQ-033 REPORT: on each res transfer, idx SHALL increment; after the transfer with idx=NUM_OUTPUTS-1, res_valid SHALL go to 0 and the FSM SHALL go to IDLE.
REQ-034 res_data SHALL stay stable while res_valid=1 and res_ready=0.
REQ-035 Outside REPORT, res_valid SHALL be 0.
REQ-036 execute=1 and setup_control other than 3'b010 SHALL never occur in the same cycle.

Reset
REQ-037 While reset=1 at a clock edge, the block SHALL enter IDLE, taking precedence over every other event.
REQ-038 Reset values: execute=0, setup_control=3'b010, data_out=0, res_valid=0, busy=0, cmd_ready=1 from the first cycle after reset.
REQ-039 Reset SHALL clear all counters, idx, remaining and the timestep counter.
REQ-040 Reset in any state (including mid-LOAD or mid-RUN) SHALL discard the operation in progress.

Verification
REQ-041 Input load: bytes 0x00, 0xA5, 0x3C back-to-back -> data_out=0xA5 then 0x3C on consecutive cycles, setup_control=000 one cycle each, then 010, FSM IDLE.
REQ-042 Weight load with res/cmd stalls: 0x40 then 80 bytes with random cmd_valid gaps -> exactly 80 single-cycle setup_control=001 pulses, data in order.
REQ-043 Run: command 0xC9 (T=10), spikes[0]=1 constant and spikes[7] toggling -> execute high 10 cycles; REPORT emits 10, 0, 0, 0, 0, 0, 0, 5.
REQ-044 Saturation and backpressure: T=64, spikes=8'hFF, run 5 times with counters cleared each run -> each count 64. With PIPE_LAT=0 and T=64, held res_ready=0 for 20 cycles -> res_data stable; then 8 bytes delivered.
REQ-045 Window edges: a spike pulse exactly PIPE_LAT-1 cycles after the first execute is not counted; a pulse at PIPE_LAT+T-1 is counted; a pulse at PIPE_LAT+T is not counted.
REQ-046 Reset mid-RUN at cycle 4 of T=10 -> the next cycle has execute=0, busy=0, cmd_ready=1; a subsequent run reports fresh counts.

Source files
------------

// File: rtl/snn_sequencer.sv
// Host-command sequencer for a spiking network: streams setup payloads into the
// network, runs it for T timesteps, counts output spikes and reports the counts.
module snn_sequencer #(
  parameter int INPUT_BYTES  = 2,
  parameter int WEIGHT_BYTES = 80,
  parameter int BN_BYTES     = 40,
  parameter int NUM_OUTPUTS  = 8,
  parameter int PIPE_LAT     = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             cmd_data,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [NUM_OUTPUTS-1:0] spikes,
  output logic [7:0]             data_out,
  output logic [2:0]             setup_control,
  output logic                   execute,
  output logic [7:0]             res_data,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic                   busy
);

  localparam int IDX_W = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;

  localparam logic [2:0] SC_NEUTRAL = 3'b010;
  localparam logic [2:0] SC_INPUT   = 3'b000;
  localparam logic [2:0] SC_WEIGHT  = 3'b001;
  localparam logic [2:0] SC_BN      = 3'b110;

  localparam logic [15:0] LAT = 16'(PIPE_LAT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_REPORT
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      rem_q, rem_d;
  logic [2:0]       code_q, code_d;
  logic [6:0]       tlen_q, tlen_d;
  logic [6:0]       tcnt_q, tcnt_d;
  logic [15:0]      cyc_q, cyc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       cnt_q [NUM_OUTPUTS];
  logic [7:0]       cnt_d [NUM_OUTPUTS];
  logic [7:0]       data_out_q, data_out_d;
  logic [2:0]       setup_q, setup_d;
  logic             execute_q, execute_d;
  logic             res_valid_q, res_valid_d;
  logic             busy_q, busy_d;
  logic             cmd_ready_q, cmd_ready_d;

  logic        cmd_xfer, res_xfer, in_win;
  logic [15:0] win_last;

  assign cmd_xfer = cmd_valid & cmd_ready_q;
  assign res_xfer = res_valid_q & res_ready;

  // cyc_q counts cycles since the first execute cycle; the window trails execute by PIPE_LAT
  assign win_last = LAT + {9'd0, tlen_q} - 16'd1;
  assign in_win   = ((state_q == S_RUN) || (state_q == S_DRAIN)) &&
                    (cyc_q >= LAT) && (cyc_q <= win_last);

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    code_d      = code_q;
    tlen_d      = tlen_q;
    tcnt_d      = tcnt_q;
    cyc_d       = cyc_q;
    idx_d       = idx_q;
    data_out_d  = data_out_q;
    setup_d     = SC_NEUTRAL;
    execute_d   = execute_q;
    res_valid_d = res_valid_q;
    busy_d      = busy_q;
    cmd_ready_d = cmd_ready_q;
    cnt_d       = cnt_q;

    for (int unsigned i = 0; i < NUM_OUTPUTS; i++) begin
      if (in_win && spikes[i] && (cnt_q[i] != 8'hFF)) begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_xfer) begin
          busy_d = 1'b1;
          case (cmd_data[7:6])
            2'b00: begin
              state_d = S_LOAD;
              rem_d   = 16'(INPUT_BYTES);
              code_d  = SC_INPUT;
            end
            2'b01: begin
              state_d = S_LOAD;
              rem_d   = 16'(WEIGHT_BYTES);
              code_d  = SC_WEIGHT;
            end
            2'b10: begin
              state_d = S_LOAD;
              rem_d   = 16'(BN_BYTES);
              code_d  = SC_BN;
            end
            default: begin
              state_d     = S_RUN;
              tlen_d      = {1'b0, cmd_data[5:0]} + 7'd1;
              tcnt_d      = {1'b0, cmd_data[5:0]};
              cyc_d       = '0;
              idx_d       = '0;
              execute_d   = 1'b1;
              cmd_ready_d = 1'b0;
              for (int unsigned i = 0; i < NUM_OUTPUTS; i++) begin
                cnt_d[i] = '0;
              end
            end
          endcase
        end
      end

      S_LOAD: begin
        if (cmd_xfer) begin
          data_out_d = cmd_data;
          setup_d    = code_q;
          rem_d      = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end
      end

      S_RUN: begin
        cyc_d = cyc_q + 16'd1;
        if (tcnt_q == '0) begin
          execute_d = 1'b0;
          // with no pipeline latency the window closes together with execute
          if (cyc_q == win_last) begin
            state_d     = S_REPORT;
            res_valid_d = 1'b1;
          end else begin
            state_d = S_DRAIN;
          end
        end else begin
          tcnt_d = tcnt_q - 7'd1;
        end
      end

      S_DRAIN: begin
        cyc_d = cyc_q + 16'd1;
        if (cyc_q == win_last) begin
          state_d     = S_REPORT;
          res_valid_d = 1'b1;
        end
      end

      S_REPORT: begin
        if (res_xfer) begin
          if (idx_q == IDX_W'(NUM_OUTPUTS - 1)) begin
            state_d     = S_IDLE;
            res_valid_d = 1'b0;
            busy_d      = 1'b0;
            cmd_ready_d = 1'b1;
            idx_d       = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      default: begin
        state_d     = S_IDLE;
        execute_d   = 1'b0;
        res_valid_d = 1'b0;
        busy_d      = 1'b0;
        cmd_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      code_q      <= SC_INPUT;
      tlen_q      <= 7'd1;
      tcnt_q      <= '0;
      cyc_q       <= '0;
      idx_q       <= '0;
      data_out_q  <= '0;
      setup_q     <= SC_NEUTRAL;
      execute_q   <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      for (int unsigned i = 0; i < NUM_OUTPUTS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      code_q      <= code_d;
      tlen_q      <= tlen_d;
      tcnt_q      <= tcnt_d;
      cyc_q       <= cyc_d;
      idx_q       <= idx_d;
      data_out_q  <= data_out_d;
      setup_q     <= setup_d;
      execute_q   <= execute_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign data_out      = data_out_q;
  assign setup_control = setup_q;
  assign execute       = execute_q;
  assign res_valid     = res_valid_q;
  assign busy          = busy_q;
  assign res_data      = cnt_q[idx_q];

endmodule

// File: tb/tb_snn_sequencer.sv
// Randomized bench for snn_sequencer: loads, runs and reports checked against
// window/count rules computed directly from the command stream and spike schedule.
module tb_snn_sequencer;

  localparam int P = 3;
  localparam int N = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] cmd_data;
  logic       cmd_valid, cmd_ready;
  logic [7:0] spikes;
  logic [7:0] data_out, res_data;
  logic [2:0] setup_control;
  logic       execute, res_valid, res_ready, busy;

  logic       cmd_valid0, cmd_ready0;
  logic [7:0] data_out0, res_data0;
  logic [2:0] setup_control0;
  logic       execute0, res_valid0, res_ready0, busy0;

  always #5 clk = ~clk;

  snn_sequencer #(.PIPE_LAT(P)) u_dut (
    .clk(clk), .reset(reset), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .spikes(spikes), .data_out(data_out),
    .setup_control(setup_control), .execute(execute), .res_data(res_data),
    .res_valid(res_valid), .res_ready(res_ready), .busy(busy)
  );

  snn_sequencer #(.PIPE_LAT(0)) u_dut0 (
    .clk(clk), .reset(reset), .cmd_data(cmd_data), .cmd_valid(cmd_valid0),
    .cmd_ready(cmd_ready0), .spikes(spikes), .data_out(data_out0),
    .setup_control(setup_control0), .execute(execute0), .res_data(res_data0),
    .res_valid(res_valid0), .res_ready(res_ready0), .busy(busy0)
  );

  int n_pass = 0;
  int n_chk  = 0;

  logic [7:0] last_data;
  logic [7:0] pl[$];
  logic [7:0] sp[128];
  int         exp_c[N];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Streams a load command followed by the payload in pl.
  task automatic do_load(input logic [7:0] cb, input bit gaps);
    logic [2:0] code;
    logic [7:0] q[$];
    int sent = 0, pulses = 0, budget = 0;
    bit pend = 0;
    code = (cb[7:6] == 2'b00) ? 3'b000 : (cb[7:6] == 2'b01) ? 3'b001 : 3'b110;
    q.push_back(cb);
    foreach (pl[i]) q.push_back(pl[i]);
    while ((sent < q.size() || pend) && budget < 2000) begin
      @(negedge clk);
      budget++;
      chk("load_setup", setup_control, pend ? code : 3'b010);
      chk("load_data", data_out, last_data);
      chk("load_ready", cmd_ready, 1);
      if (pend) pulses++;
      pend = 0;
      if (sent < q.size() && (!gaps || $urandom_range(0, 2) != 0)) begin
        cmd_valid = 1'b1;
        cmd_data  = q[sent];
        if (cmd_ready) begin
          if (sent > 0) begin
            pend      = 1;
            last_data = q[sent];
          end
          sent++;
        end
      end else begin
        cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    chk("load_budget", budget < 2000, 1);
    @(negedge clk);
    chk("load_pulses", pulses, pl.size());
    chk("load_idle_busy", busy, 0);
    chk("load_idle_setup", setup_control, 3'b010);
  endtask

  task automatic collect();
    int idx = 0, budget = 0;
    bit held = 0, rr;
    logic [7:0] hv = '0;
    while (idx < N && budget < 3000) begin
      @(negedge clk);
      budget++;
      if (held) chk("res_stable", res_data, hv);
      chk("res_valid", res_valid, 1);
      rr = ($urandom_range(0, 2) != 0);
      res_ready = rr;
      if (rr) begin
        chk($sformatf("res_data%0d", idx), res_data, exp_c[idx]);
        idx++;
        held = 0;
      end else begin
        held = 1;
        hv   = res_data;
      end
    end
    chk("report_count", idx, N);
    @(negedge clk);
    res_ready = 1'b0;
    chk("report_exit_valid", res_valid, 0);
    chk("report_exit_busy", busy, 0);
    chk("report_exit_ready", cmd_ready, 1);
  endtask

  // mode 0 random, 1 lane0 steady + lane7 toggling, 2 all ones, 3 window-edge pulses
  task automatic do_run(input int t, input int mode);
    int ktot = P + t + 2;
    for (int k = 0; k < ktot; k++) begin
      case (mode)
        0:       sp[k] = 8'($urandom);
        1:       sp[k] = 8'h01 | ((k % 2 == 0) ? 8'h80 : 8'h00);
        2:       sp[k] = 8'hFF;
        default: sp[k] = ((k == P - 1) ? 8'h02 : 8'h00) | ((k == P + t - 1) ? 8'h04 : 8'h00)
                       | ((k == P + t) ? 8'h08 : 8'h00);
      endcase
    end
    for (int i = 0; i < N; i++) begin
      int c = 0;
      for (int k = P; k < P + t; k++) c += sp[k][i];
      exp_c[i] = (c > 255) ? 255 : c;
    end
    @(negedge clk);
    chk("run_cmd_ready", cmd_ready, 1);
    cmd_data  = 8'hC0 | 8'(t - 1);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k < ktot; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("execute_k%0d", k), execute, (k < t) ? 1 : 0);
      chk("run_setup", setup_control, 3'b010);
      chk("run_cmd_ready", cmd_ready, 0);
      chk("run_busy", busy, 1);
      chk($sformatf("res_valid_k%0d", k), res_valid, (k >= P + t) ? 1 : 0);
      spikes = sp[k];
    end
    @(negedge clk);
    spikes = '0;
    collect();
  endtask

  initial begin
    int b;
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_valid0 = 1'b0;
    res_ready = 1'b0; res_ready0 = 1'b0;
    spikes = '0; cmd_data = '0; last_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_execute", execute, 0);
    chk("rst_setup", setup_control, 3'b010);
    chk("rst_data_out", data_out, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 1);

    pl = {8'hA5, 8'h3C};
    do_load(8'h00, 0);
    pl.delete();
    repeat (80) pl.push_back(8'($urandom));
    do_load(8'h40, 1);
    pl.delete();
    repeat (40) pl.push_back(8'($urandom));
    do_load(8'h80 | 8'($urandom_range(0, 63)), 1);
    pl.delete();
    repeat (2) pl.push_back(8'($urandom));
    do_load(8'h00 | 8'($urandom_range(0, 63)), 1);

    do_run(10, 1);
    repeat (5) do_run(64, 2);
    do_run(10, 3);
    do_run(1, 3);
    do_run(64, 3);
    repeat (6) do_run($urandom_range(1, 64), 0);

    // abort a run on its fourth execute cycle
    @(negedge clk);
    cmd_data = 8'hC9; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    spikes = 8'hFF;
    repeat (3) @(negedge clk);
    chk("pre_reset_execute", execute, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    spikes = '0;
    last_data = '0;
    chk("midrst_execute", execute, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cmd_ready", cmd_ready, 1);
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_setup", setup_control, 3'b010);
    do_run(10, 0);

    // zero-latency instance: saturating full run held under backpressure
    spikes = 8'hFF;
    @(negedge clk);
    cmd_data = 8'hFF; cmd_valid0 = 1'b1;
    @(negedge clk);
    cmd_valid0 = 1'b0;
    b = 0;
    while (!res_valid0 && b < 200) begin
      @(negedge clk);
      b++;
    end
    chk("lat0_report_cycle", b, 64);
    spikes = '0;
    repeat (20) begin
      @(negedge clk);
      chk("lat0_hold_valid", res_valid0, 1);
      chk("lat0_hold_data", res_data0, 64);
    end
    res_ready0 = 1'b1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("lat0_valid%0d", i), res_valid0, 1);
      chk($sformatf("lat0_data%0d", i), res_data0, 64);
      @(negedge clk);
    end
    res_ready0 = 1'b0;
    chk("lat0_exit_valid", res_valid0, 0);
    chk("lat0_exit_busy", busy0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
